// File: rtl/aes_block_loader.sv
// aes_block_loader: assembles a byte stream into 4x4 key and plaintext
// matrices (column-major) and hands completed data blocks, together with
// the active key, to the cipher over a valid/ready handshake.
module aes_block_loader (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_byte,
  input  logic                 in_kind,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [3:0][3:0][7:0] key_o,
  output logic [3:0][3:0][7:0] data_o,
  output logic                 key_valid,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 no_key_err
);

  localparam int unsigned CntW    = 4;
  localparam int unsigned LastIdx = 15;

  typedef enum logic {
    LOAD = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  kind_q, kind_d;
  logic                  pend_key_q, pend_key_d;
  logic [3:0][3:0][7:0]  asm_q, asm_d;
  logic [3:0][3:0][7:0]  key_q, key_d;
  logic [3:0][3:0][7:0]  data_q, data_d;
  logic                  key_valid_q, key_valid_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;
  logic                  no_key_err_q, no_key_err_d;

  logic                  accept;
  logic                  drain;
  logic                  last;
  logic                  blk_kind;
  logic                  out_free;

  // Handshake qualifiers; out_ready may steer the completion decision.
  always_comb begin
    accept   = in_valid && in_ready_q && (state_q == LOAD);
    drain    = out_valid_q && out_ready;
    last     = accept && (cnt_q == CntW'(LastIdx));
    blk_kind = (cnt_q == '0) ? in_kind : kind_q;
    out_free = !out_valid_q || drain;
  end

  // Next-state, assembly and output-register logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    kind_d       = kind_q;
    pend_key_d   = pend_key_q;
    asm_d        = asm_q;
    key_d        = key_q;
    data_d       = data_q;
    key_valid_d  = key_valid_q;
    out_valid_d  = out_valid_q;
    no_key_err_d = 1'b0;

    case (state_q)
      LOAD: begin
        if (drain) begin
          out_valid_d = 1'b0;
        end
        if (accept) begin
          cnt_d = CntW'(cnt_q + CntW'(1));
          if (cnt_q == '0) begin
            kind_d = in_kind;
          end
          // Outer index is the column (word), inner the row.
          asm_d[cnt_q[3:2]][cnt_q[1:0]] = in_byte;
        end
        if (last) begin
          if (!blk_kind) begin
            if (!key_valid_q) begin
              // No key to encrypt with: drop the block and flag it.
              no_key_err_d = 1'b1;
            end else if (out_free) begin
              data_d      = asm_d;
              out_valid_d = 1'b1;
            end else begin
              state_d    = HOLD;
              pend_key_d = 1'b0;
            end
          end else begin
            if (out_free) begin
              key_d       = asm_d;
              key_valid_d = 1'b1;
            end else begin
              // Defer the key swap so the held block keeps its key.
              state_d    = HOLD;
              pend_key_d = 1'b1;
            end
          end
        end
      end
      HOLD: begin
        if (drain) begin
          if (pend_key_q) begin
            key_d       = asm_q;
            key_valid_d = 1'b1;
            out_valid_d = 1'b0;
          end else begin
            data_d      = asm_q;
            out_valid_d = 1'b1;
          end
          state_d = LOAD;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase

    in_ready_d = (state_d == LOAD);
  end

  // State and output registers; reset discards everything including the key.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= LOAD;
      cnt_q        <= '0;
      kind_q       <= 1'b0;
      pend_key_q   <= 1'b0;
      asm_q        <= '0;
      key_q        <= '0;
      data_q       <= '0;
      key_valid_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      no_key_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      kind_q       <= kind_d;
      pend_key_q   <= pend_key_d;
      asm_q        <= asm_d;
      key_q        <= key_d;
      data_q       <= data_d;
      key_valid_q  <= key_valid_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      no_key_err_q <= no_key_err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign key_o      = key_q;
  assign data_o     = data_q;
  assign key_valid  = key_valid_q;
  assign out_valid  = out_valid_q;
  assign no_key_err = no_key_err_q;

endmodule

// File: doc/aes_block_loader.md
# aes_block_loader

Byte-stream front end for the AES cipher stage. It assembles incoming bytes into 4x4 byte matrices for the key and for plaintext blocks, and holds the current key stable across any number of data blocks. It presents each completed data block with the active key to the cipher over a valid/ready handshake. It sits directly upstream of the `Cipher` block and drives that block's `key` and `data` inputs.

## Interface
Parameters: none; the byte width (8) and matrix shape (4x4) are fixed by the cipher.
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_byte`  in  8  stream byte
- `in_kind`  in  1  0 = data, 1 = key; sampled only on the first byte of a block
- `in_valid`  in  1  `in_byte` is valid
- `in_ready`  out  1  loader accepts a byte this cycle
- `key_o`  out  4x4x8  active key matrix, feeds `Cipher.key`
- `data_o`  out  4x4x8  held plaintext block, feeds `Cipher.data`
- `key_valid`  out  1  a complete key has been loaded
- `out_valid`  out  1  `data_o` holds an unconsumed block
- `out_ready`  in  1  downstream consumes the block
- `no_key_err`  out  1  one-cycle pulse when a data block completes with `key_valid` = 0

## Operation
- **Byte acceptance.** A byte is accepted when `in_valid && in_ready`. A 4-bit counter `cnt` increments on each accepted byte and wraps from 15 to 0.
- **Block kind.** At `cnt==0` the accepted byte latches `in_kind` into `kind_q`. `in_kind` on bytes 1..15 is ignored.
- **Byte placement.** Byte i (i = `cnt`) is written to assembly matrix entry `[i/4][i%4]`, outer index = column (word), AES column-major order. Assembly storage is separate from `key_o` and `data_o`.
- **State machine.** States are LOAD and HOLD. `in_ready` = 1 in LOAD and 0 in HOLD.
- **Data block completion** (16th byte accepted, `kind_q`=0):
  - If `key_valid`=0: the block is discarded, `no_key_err` pulses, and the FSM stays in LOAD.
  - Else if `out_valid`=0, or (`out_valid && out_ready`) in the same cycle: the assembly matrix is copied to `data_o`, `out_valid`=1, and the FSM stays in LOAD.
  - Else: the FSM goes to HOLD with a pending-data flag set.
- **Key block completion** (16th byte accepted, `kind_q`=1):
  - If `out_valid`=0, or it drains in the same cycle: the assembly matrix is copied to `key_o` and `key_valid`=1.
  - Else: the FSM goes to HOLD with a pending-key flag set, so a held block is never exposed to a changed key.
- **HOLD.** The FSM waits for `out_valid && out_ready`. On that edge:
  - pending data: `data_o` is loaded and `out_valid` stays 1;
  - pending key: `key_o` is loaded and `out_valid` goes to 0.
  - In both cases the FSM returns to LOAD.
- **Drain.** `out_valid && out_ready` with no replacement block clears `out_valid`.
- **Reloading the key.** A new key may be loaded at any time and replaces the old key. `key_valid` never falls except on reset.

## Timing
- **Reset.** While `rst`=0: `cnt`=0, FSM=LOAD, all matrices = 0, and `key_valid`, `out_valid`, `no_key_err`, `in_ready` = 0. `in_ready` rises the first cycle after reset release.
- **Reset mid-block.** Partial bytes and any pending block are discarded, and the key is lost.
- **Latency.** The 16th byte accepted at edge N gives `out_valid` (or the `key_o`/`key_valid` update) visible from edge N to N+1. Throughput is one byte per cycle with no bubbles when `out_ready` is held 1.
- **Output stability.** `data_o` and `key_o` are stable whenever `out_valid`=1 and `out_ready`=0.
- **Combinational path.** `out_ready` may combinationally affect the completion decision; no other combinational input-to-output path is allowed except `out_ready` to nothing (all outputs are registered).

## Test plan
- **Basic load.** After reset, stream a key of bytes 0x00..0x0F then a data block 0x10..0x1F with `out_ready`=1. Expect `key_o[1][2]`=0x06, `key_valid`=1 after byte 16, `data_o[3][3]`=0x1F, and `out_valid` one cycle after the 32nd byte.
- **No key.** Stream 16 data bytes after reset with no key. Expect `no_key_err` high for exactly one cycle, `out_valid`=0, and `cnt` back to 0.
- **Backpressure.** Hold `out_ready`=0 and send two data blocks. Expect the first block held unchanged and `in_ready`=0 from the 32nd data byte. Raise `out_ready` for one cycle: `data_o` switches to block 2, `out_valid` stays 1, and `in_ready` returns to 1.
- **Key change behind a held block.** With a block held and `out_ready`=0, send a new key of all 0xAA. Expect `key_o` unchanged until the handshake, then `key_o`=0xAA everywhere and `out_valid`=0.
- **Simultaneous events.** Complete the 16th data byte in the same cycle `out_ready`=1 with `out_valid`=1. Expect no HOLD, `in_ready` to stay 1, and `data_o` to show the new block next cycle.
- **Reset mid-operation.** Assert `rst`=0 after 7 bytes of a data block. Expect every output 0 immediately. After release, a fresh 16-byte key is placed starting at index `[0][0]`.
